// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   // Fetch control states; encoding is visible on debug taps, keep it fixed.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   localparam int          FETCH_Q_DEPTH = 2;
   localparam logic [31:0] PC_STEP       = 32'd4;

   // One buffered instruction together with the address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instr}. Flush wins over push/pop. The owner
// guarantees no push into a full queue unless a pop happens on the same edge,
// and no pop from an empty queue.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t din_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t [FETCH_Q_DEPTH-1:0] slot_q;
   logic                             rd_ptr_q;
   logic                             wr_ptr_q;
   logic [1:0]                       count_q;

   // Storage, pointers and occupancy; a full queue has wr_ptr == rd_ptr, so a
   // push alongside a pop overwrites the slot being retired.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_q   <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            slot_q[wr_ptr_q] <= din_i;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_o  = slot_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: boots a program image into the RAM while IDLE,
// then fetches sequentially into a 2-entry queue feeding decode.
// Optional feature: define FETCH_MISALIGN_EN to trap misaligned redirects
// into the FAULT state; otherwise redirect targets are forced word-aligned.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int          MemDepthInBitWidth = 16,
   parameter logic [31:0] RESET_PC           = 32'h0000_0000
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          load_valid,
   input  logic [31:0]                   load_data,
   output logic                          load_ready,
   output logic [MemDepthInBitWidth-1:0] mem_addr,
   output logic                          mem_we,
   output logic [31:0]                   mem_d,
   input  logic [31:0]                   mem_q,
   input  logic                          redirect_valid,
   input  logic [31:0]                   redirect_pc,
   output logic                          instr_valid,
   input  logic                          instr_ready,
   output logic [31:0]                   instr_data,
   output logic [31:0]                   instr_pc,
   output logic                          fetch_fault
);

   localparam int AW = MemDepthInBitWidth;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [AW-1:0] load_ptr_q, load_ptr_d;

   logic          q_push, q_pop, q_flush;
   logic [1:0]    q_count;
   fetch_entry_t  q_din, q_head;

   logic          idle, run;

   assign idle  = (state_q == ST_IDLE);
   assign run   = (state_q == ST_RUN);
   assign q_din = '{pc: pc_q, instr: mem_q};
   // A pop that coincides with a flush is simply dropped inside the queue.
   assign q_pop = instr_valid && instr_ready;

   // State, PC and boot pointer registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         load_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         load_ptr_q <= load_ptr_d;
      end
   end

   // Next-state, PC update and queue control; stop outranks start and redirect.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      load_ptr_d = load_ptr_q;
      q_push     = 1'b0;
      q_flush    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_valid) load_ptr_d = load_ptr_q + AW'(PC_STEP);
            if (!stop && start) begin
               state_d = ST_RUN;
               pc_d    = RESET_PC;
               q_flush = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               q_flush = 1'b1;
            end else if (redirect_valid) begin
               q_flush = 1'b1;
`ifdef FETCH_MISALIGN_EN
               if (redirect_pc[1:0] != 2'b00) state_d = ST_FAULT;
               else                           pc_d    = redirect_pc;
`else
               pc_d = redirect_pc & ~32'd3;
`endif
            end else begin
               q_push = (q_count < 2'(FETCH_Q_DEPTH)) || q_pop;
               if (q_push) pc_d = pc_q + PC_STEP;
            end
         end
         ST_FAULT: begin
            if (stop) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   fetch_queue u_queue (
      .clock   (clock),
      .reset_n (reset_n),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .flush_i (q_flush),
      .din_i   (q_din),
      .head_o  (q_head),
      .count_o (q_count)
   );

   // Boot port is only live in IDLE; gating with reset_n forces all outputs
   // low the moment reset asserts, before any clock edge.
   assign load_ready  = idle && reset_n;
   assign mem_we      = idle && reset_n && load_valid;
   assign mem_d       = (idle && reset_n) ? load_data : 32'd0;
   assign mem_addr    = idle ? load_ptr_q : pc_q[AW-1:0];

   assign instr_valid = run && (q_count != 2'd0);
   assign instr_data  = instr_valid ? q_head.instr : 32'd0;
   assign instr_pc    = instr_valid ? q_head.pc    : 32'd0;

`ifdef FETCH_MISALIGN_EN
   assign fetch_fault = (state_q == ST_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, streaming fetch, backpressure,
// redirect, misaligned redirect, reset mid-run, and boot-pointer wrap.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start, stop, load_valid, redirect_valid, instr_ready;
   logic [31:0] load_data, redirect_pc;
   logic        load_ready, mem_we, instr_valid, fetch_fault;
   logic [15:0] mem_addr;
   logic [31:0] mem_d, mem_q, instr_data, instr_pc;

   // second instance with a 16-byte RAM for the wrap case
   logic        start4, stop4, load_valid4, redirect_valid4, instr_ready4;
   logic [31:0] load_data4, redirect_pc4;
   logic        load_ready4, mem_we4, instr_valid4, fetch_fault4;
   logic [3:0]  mem_addr4;
   logic [31:0] mem_d4, mem_q4, instr_data4, instr_pc4;

   logic [31:0] ram  [0:16383];
   logic [31:0] ram4 [0:3];

   int tests = 0;
   int fails = 0;

   logic [31:0] boot [0:3];
   logic [3:0]  wrap_addr [0:4];

   always #5 clock = ~clock;

   instr_fetch_unit dut (
      .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
   );

   instr_fetch_unit #(.MemDepthInBitWidth(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .start(start4), .stop(stop4),
      .load_valid(load_valid4), .load_data(load_data4), .load_ready(load_ready4),
      .mem_addr(mem_addr4), .mem_we(mem_we4), .mem_d(mem_d4), .mem_q(mem_q4),
      .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
      .instr_valid(instr_valid4), .instr_ready(instr_ready4),
      .instr_data(instr_data4), .instr_pc(instr_pc4), .fetch_fault(fetch_fault4)
   );

   // RAM models: combinational read, write on clock
   assign mem_q  = ram[mem_addr[15:2]];
   assign mem_q4 = ram4[mem_addr4[3:2]];
   always @(posedge clock) begin
      if (mem_we)  ram[mem_addr[15:2]]  <= mem_d;
      if (mem_we4) ram4[mem_addr4[3:2]] <= mem_d4;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      boot[0] = 32'h11; boot[1] = 32'h22; boot[2] = 32'h33; boot[3] = 32'h44;
      wrap_addr[0] = 4'h0; wrap_addr[1] = 4'h4; wrap_addr[2] = 4'h8;
      wrap_addr[3] = 4'hC; wrap_addr[4] = 4'h0;
      for (int i = 0; i < 16384; i++) ram[i] = 32'd0;
      for (int i = 0; i < 4; i++) ram4[i] = 32'd0;
      start = 0; stop = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
      start4 = 0; stop4 = 0; load_valid4 = 0; load_data4 = 0;
      redirect_valid4 = 0; redirect_pc4 = 0; instr_ready4 = 0;

      // Reset: everything low even with a boot word offered
      reset_n = 0; load_valid = 1; load_data = 32'hDEAD_BEEF;
      tick(); tick();
      chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_d", mem_d, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_instr_data", instr_data, 32'd0);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      load_valid = 0;
      reset_n = 1;
      #1;
      chk("idle_load_ready", {31'd0, load_ready}, 32'd1);

      // Boot four words
      for (int i = 0; i < 4; i++) begin
         load_valid = 1; load_data = boot[i];
         #1;
         chk("boot_we", {31'd0, mem_we}, 32'd1);
         chk("boot_addr", {16'd0, mem_addr}, 32'(i * 4));
         chk("boot_d", mem_d, boot[i]);
         tick();
      end
      load_valid = 0;
      #1;
      chk("boot_we_off", {31'd0, mem_we}, 32'd0);
      chk("boot_ptr", {16'd0, mem_addr}, 32'h10);
      for (int i = 0; i < 4; i++) chk("boot_ram", ram[i], boot[i]);

      // stop beats start
      start = 1; stop = 1;
      tick();
      start = 0; stop = 0;
      chk("stop_beats_start", {31'd0, load_ready}, 32'd1);

      // Streaming run with ready held high
      instr_ready = 1; start = 1;
      tick();
      start = 0;
      chk("run_e0_valid", {31'd0, instr_valid}, 32'd0);
      chk("run_e0_addr", {16'd0, mem_addr}, 32'd0);
      chk("run_load_ready", {31'd0, load_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("run_valid", {31'd0, instr_valid}, 32'd1);
         chk("run_pc", instr_pc, 32'(i * 4));
         chk("run_data", instr_data, boot[i]);
      end
      stop = 1;
      tick();
      stop = 0;
      chk("stop_valid", {31'd0, instr_valid}, 32'd0);
      chk("stop_ptr_kept", {16'd0, mem_addr}, 32'h10);

      // Backpressure: queue fills to two, PC holds at 8
      instr_ready = 0; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_pc", instr_pc, 32'h0);
         chk("bp_data", instr_data, 32'h11);
         chk("bp_addr", {16'd0, mem_addr}, (i == 0) ? 32'h4 : 32'h8);
      end
      instr_ready = 1;
      tick();
      chk("bp_rel_pc", instr_pc, 32'h4);
      chk("bp_rel_data", instr_data, 32'h22);
      tick();
      chk("bp_rel2_pc", instr_pc, 32'h8);
      chk("bp_rel2_data", instr_data, 32'h33);
      stop = 1;
      tick();
      stop = 0;

      // Redirect to 0x8: the in-flight 0x4 fetch is dropped
      start = 1;
      tick();
      start = 0;
      tick();
      chk("rd_head_pc", instr_pc, 32'h0);
      redirect_valid = 1; redirect_pc = 32'h8;
      tick();
      redirect_valid = 0;
      chk("rd_flush_valid", {31'd0, instr_valid}, 32'd0);
      chk("rd_addr", {16'd0, mem_addr}, 32'h8);
      tick();
      chk("rd_valid", {31'd0, instr_valid}, 32'd1);
      chk("rd_pc", instr_pc, 32'h8);
      chk("rd_data", instr_data, 32'h33);
      tick();
      chk("rd_next_pc", instr_pc, 32'hC);
      chk("rd_next_data", instr_data, 32'h44);
      stop = 1;
      tick();
      stop = 0;

      // Redirect is ignored in IDLE
      redirect_valid = 1; redirect_pc = 32'h40;
      tick();
      redirect_valid = 0;
      chk("idle_rd_addr", {16'd0, mem_addr}, 32'h10);
      chk("idle_rd_valid", {31'd0, instr_valid}, 32'd0);

      // Misaligned redirect to 0x6
      start = 1;
      tick();
      start = 0;
      tick();
      redirect_valid = 1; redirect_pc = 32'h6;
      tick();
      redirect_valid = 0;
`ifdef FETCH_MISALIGN_EN
      chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
      chk("mis_valid", {31'd0, instr_valid}, 32'd0);
      tick(); tick();
      chk("mis_fault_hold", {31'd0, fetch_fault}, 32'd1);
      chk("mis_valid_hold", {31'd0, instr_valid}, 32'd0);
      stop = 1;
      tick();
      stop = 0;
      chk("mis_fault_clr", {31'd0, fetch_fault}, 32'd0);
      chk("mis_idle", {31'd0, load_ready}, 32'd1);
`else
      chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
      chk("mis_valid", {31'd0, instr_valid}, 32'd0);
      chk("mis_addr", {16'd0, mem_addr}, 32'h4);
      tick();
      chk("mis_pc", instr_pc, 32'h4);
      chk("mis_data", instr_data, 32'h22);
      stop = 1;
      tick();
      stop = 0;
`endif

      // Reset mid-run: outputs drop immediately
      start = 1;
      tick();
      start = 0;
      tick();
      chk("mid_valid", {31'd0, instr_valid}, 32'd1);
      reset_n = 0;
      #1;
      chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_rst_pc", instr_pc, 32'd0);
      chk("mid_rst_data", instr_data, 32'd0);
      chk("mid_rst_addr", {16'd0, mem_addr}, 32'd0);
      chk("mid_rst_load_ready", {31'd0, load_ready}, 32'd0);
      tick();
      reset_n = 1;
      #1;

      // Boot pointer wrap on the 16-byte instance
      for (int i = 0; i < 5; i++) begin
         load_valid4 = 1; load_data4 = 32'hA0 + 32'(i);
         #1;
         chk("wrap_we", {31'd0, mem_we4}, 32'd1);
         chk("wrap_addr", {28'd0, mem_addr4}, {28'd0, wrap_addr[i]});
         tick();
      end
      load_valid4 = 0;
      #1;
      chk("wrap_ram0", ram4[0], 32'hA4);
      chk("wrap_ram1", ram4[1], 32'hA1);
      chk("wrap_ptr", {28'd0, mem_addr4}, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
